hmc_rx_lane_aligner: RTL



---
 rtl/hmc_rx_lane_aligner.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/hmc_rx_lane_aligner.sv
`default_nettype none
// ============================================================================
// Module   : hmc_rx_lane_aligner
// Purpose  : Per-lane RX word aligner with bit-slip hunting, optional lane
//            polarity detection and lock tracking for the HMC PHY boundary.
// Revision : 1.0 - initial release
// ============================================================================
module hmc_rx_lane_aligner #(
    parameter int NUM_LANES            = 8,
    parameter int DWIDTH               = 256,
    parameter logic [DWIDTH/NUM_LANES-1:0] ALIGN_PATTERN = 32'h7E81_0FF0,
    parameter int DETECT_LANE_POLARITY = 1,
    parameter int SLIP_WAIT            = 8,
    parameter int LOCK_COUNT           = 16,
    parameter int LOSS_COUNT           = 4,
    parameter int MAX_SLIPS            = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DWIDTH-1:0]    phy_data_rx_phy2link,
    input  logic                 phy_rx_ready,
    input  logic                 align_en,
    output logic [NUM_LANES-1:0] phy_bit_slip,
    output logic [NUM_LANES-1:0] phy_lane_polarity,
    output logic [NUM_LANES-1:0] lane_locked,
    output logic                 all_locked,
    output logic [NUM_LANES-1:0] lane_fail
);

    localparam int c_lane_w  = DWIDTH / NUM_LANES;
    localparam int c_slip_w  = $clog2(MAX_SLIPS + 1);
    localparam int c_wait_w  = $clog2(SLIP_WAIT + 1);
    localparam int c_match_w = $clog2(LOCK_COUNT + 1);
    localparam int c_loss_w  = $clog2(LOSS_COUNT + 1);

    localparam logic [c_slip_w-1:0]  c_slip_last  = c_slip_w'(MAX_SLIPS - 1);
    localparam logic [c_wait_w-1:0]  c_wait_last  = c_wait_w'(SLIP_WAIT);
    localparam logic [c_match_w-1:0] c_match_one  = c_match_w'(1);
    localparam logic [c_match_w-1:0] c_match_last = c_match_w'(LOCK_COUNT - 1);
    localparam logic [c_loss_w-1:0]  c_loss_last  = c_loss_w'(LOSS_COUNT - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_hunt    = 3'd1;
    localparam logic [2:0] c_st_slip    = 3'd2;
    localparam logic [2:0] c_st_wait    = 3'd3;
    localparam logic [2:0] c_st_locking = 3'd4;
    localparam logic [2:0] c_st_locked  = 3'd5;

    logic [DWIDTH-1:0] r_rx_q;
    logic              r_all_locked;
    logic              w_run;

    assign w_run = phy_rx_ready && align_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_q <= '0;
        end else begin
            r_rx_q <= phy_data_rx_phy2link;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [2:0]           r_state;
            logic [c_slip_w-1:0]  r_slip_cnt;
            logic [c_wait_w-1:0]  r_wait_cnt;
            logic [c_match_w-1:0] r_match_cnt;
            logic [c_loss_w-1:0]  r_loss_cnt;
            logic                 r_bit_slip;
            logic                 r_polarity;
            logic                 r_locked;
            logic                 r_fail;
            logic [c_lane_w-1:0]  w_word;
            logic                 w_match;
            logic                 w_inv_match;

            assign w_word      = r_rx_q[gi*c_lane_w +: c_lane_w];
            assign w_match     = (w_word == ALIGN_PATTERN);
            assign w_inv_match = (DETECT_LANE_POLARITY != 0) && (w_word == ~ALIGN_PATTERN);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state     <= c_st_idle;
                    r_slip_cnt  <= '0;
                    r_wait_cnt  <= '0;
                    r_match_cnt <= '0;
                    r_loss_cnt  <= '0;
                    r_bit_slip  <= 1'b0;
                    r_polarity  <= 1'b0;
                    r_locked    <= 1'b0;
                    r_fail      <= 1'b0;
                end else if (!w_run) begin
                    // polarity and fail are deliberately kept across a forced idle
                    r_state     <= c_st_idle;
                    r_slip_cnt  <= '0;
                    r_wait_cnt  <= '0;
                    r_match_cnt <= '0;
                    r_loss_cnt  <= '0;
                    r_bit_slip  <= 1'b0;
                    r_locked    <= 1'b0;
                end else begin
                    r_bit_slip <= 1'b0;
                    case (r_state)
                        c_st_idle: begin
                            r_slip_cnt  <= '0;
                            r_wait_cnt  <= '0;
                            r_match_cnt <= '0;
                            r_loss_cnt  <= '0;
                            r_state     <= c_st_hunt;
                        end
                        c_st_hunt: begin
                            r_wait_cnt <= '0;
                            if (w_match) begin
                                r_match_cnt <= c_match_one;
                                r_loss_cnt  <= '0;
                                if (LOCK_COUNT == 1) begin
                                    r_locked <= 1'b1;
                                    r_state  <= c_st_locked;
                                end else begin
                                    r_state  <= c_st_locking;
                                end
                            end else if (w_inv_match) begin
                                r_polarity <= ~r_polarity;
                                r_state    <= c_st_wait;
                            end else begin
                                r_bit_slip <= 1'b1;
                                r_state    <= c_st_slip;
                            end
                        end
                        c_st_slip: begin
                            if (r_slip_cnt == c_slip_last) begin
                                r_fail     <= 1'b1;
                                r_slip_cnt <= '0;
                            end else begin
                                r_slip_cnt <= r_slip_cnt + 1'b1;
                            end
                            r_wait_cnt <= '0;
                            r_state    <= c_st_wait;
                        end
                        c_st_wait: begin
                            // one extra cycle lets a post-slip word clear the rx_q stage
                            if (r_wait_cnt == c_wait_last) begin
                                r_state <= c_st_hunt;
                            end else begin
                                r_wait_cnt <= r_wait_cnt + 1'b1;
                            end
                        end
                        c_st_locking: begin
                            if (w_match) begin
                                r_match_cnt <= r_match_cnt + 1'b1;
                                if (r_match_cnt == c_match_last) begin
                                    r_locked   <= 1'b1;
                                    r_loss_cnt <= '0;
                                    r_state    <= c_st_locked;
                                end
                            end else begin
                                r_match_cnt <= '0;
                                r_state     <= c_st_hunt;
                            end
                        end
                        c_st_locked: begin
                            if (w_match) begin
                                r_loss_cnt <= '0;
                            end else if (r_loss_cnt == c_loss_last) begin
                                r_loss_cnt  <= '0;
                                r_match_cnt <= '0;
                                r_slip_cnt  <= '0;
                                r_locked    <= 1'b0;
                                r_state     <= c_st_hunt;
                            end else begin
                                r_loss_cnt <= r_loss_cnt + 1'b1;
                            end
                        end
                        default: begin
                            r_locked <= 1'b0;
                            r_state  <= c_st_idle;
                        end
                    endcase
                end
            end

            assign phy_bit_slip[gi]      = r_bit_slip;
            assign phy_lane_polarity[gi] = r_polarity;
            assign lane_locked[gi]       = r_locked;
            assign lane_fail[gi]         = r_fail;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_all_locked <= 1'b0;
        end else begin
            r_all_locked <= &lane_locked;
        end
    end

    assign all_locked = r_all_locked;

endmodule
`default_nettype wire
